// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: fetches 8-bit instructions from synchronous
// program memory, emits a one-hot op vector, resolves jumps and waits on I/O.
module instr_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  input  logic            z_flag,
  input  logic            c_flag,
  input  logic            io_in_valid,
  input  logic            io_out_ready,
  output logic [15:0]     op_vec,
  output logic [7:0]      ir,
  output logic            exec_stb,
  output logic            illegal,
  output logic            halted,
  output logic [PC_W-1:0] pc
);

  localparam logic [15:0] OP_MOVA = 16'h8000;
  localparam logic [15:0] OP_MOVB = 16'h4000;
  localparam logic [15:0] OP_MOVC = 16'h2000;
  localparam logic [15:0] OP_ADD  = 16'h1000;
  localparam logic [15:0] OP_SUB  = 16'h0800;
  localparam logic [15:0] OP_AND  = 16'h0400;
  localparam logic [15:0] OP_NOT  = 16'h0200;
  localparam logic [15:0] OP_RSR  = 16'h0100;
  localparam logic [15:0] OP_RSL  = 16'h0080;
  localparam logic [15:0] OP_JMP  = 16'h0040;
  localparam logic [15:0] OP_JZ   = 16'h0020;
  localparam logic [15:0] OP_JC   = 16'h0010;
  localparam logic [15:0] OP_IN   = 16'h0008;
  localparam logic [15:0] OP_OUT  = 16'h0004;
  localparam logic [15:0] OP_NOP  = 16'h0002;
  localparam logic [15:0] OP_HALT = 16'h0001;

  localparam int B_JMP = 6;
  localparam int B_JZ  = 5;
  localparam int B_JC  = 4;
  localparam int B_IN  = 3;
  localparam int B_OUT = 2;
  localparam int B_HLT = 0;

  typedef enum logic [2:0] {
    st_fetch   = 3'd0,
    st_decode  = 3'd1,
    st_operand = 3'd2,
    st_exec    = 3'd3,
    st_iowait  = 3'd4,
    st_halt    = 3'd5
  } state_t;

  // An all-zero result marks an undecodable encoding.
  function automatic logic [15:0] decode_op(input logic [7:0] instr);
    logic [15:0] op;
    op = 16'h0000;
    case (instr[7:4])
      4'b1100: begin
        if (instr[3:2] == 2'b11) begin
          op = OP_MOVB;
        end else if (instr[1:0] == 2'b11) begin
          op = OP_MOVC;
        end else begin
          op = OP_MOVA;
        end
      end
      4'b1001: op = OP_ADD;
      4'b0110: op = OP_SUB;
      4'b1011: op = OP_AND;
      4'b0101: op = OP_NOT;
      4'b1010: begin
        case (instr[1:0])
          2'b00:   op = OP_RSR;
          2'b11:   op = OP_RSL;
          default: op = 16'h0000;
        endcase
      end
      4'b0011: begin
        case (instr[3:0])
          4'b0000: op = OP_JMP;
          4'b0001: op = OP_JZ;
          4'b0010: op = OP_JC;
          default: op = 16'h0000;
        endcase
      end
      4'b0010: op = OP_IN;
      4'b0100: op = OP_OUT;
      4'b0111: op = (instr == 8'h70) ? OP_NOP : 16'h0000;
      4'b1000: op = (instr == 8'h80) ? OP_HALT : 16'h0000;
      default: op = 16'h0000;
    endcase
    return op;
  endfunction

  state_t          state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [7:0]      ir_r, ir_s;
  logic [15:0]     op_vec_r, op_vec_s;
  logic            illegal_r, illegal_s;
  logic            halt_pend_r, halt_pend_s;
  logic            mem_rd_s, exec_stb_s;
  logic [15:0]     dec_op_s;
  logic [PC_W-1:0] pc_inc_s, target_s;
  logic            taken_s, io_done_s, is_jump_s;

  // Jump target is the operand byte, zero-extended or truncated to PC_W.
  if (PC_W > 8) begin : g_target_ext
    assign target_s = {{(PC_W-8){1'b0}}, mem_rdata};
  end else begin : g_target_trunc
    assign target_s = mem_rdata[PC_W-1:0];
  end

  assign dec_op_s  = decode_op(mem_rdata);
  assign is_jump_s = dec_op_s[B_JMP] | dec_op_s[B_JZ] | dec_op_s[B_JC];
  assign pc_inc_s  = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  assign taken_s   = op_vec_r[B_JMP] | (op_vec_r[B_JZ] & z_flag) | (op_vec_r[B_JC] & c_flag);
  assign io_done_s = (op_vec_r[B_IN] & io_in_valid) | (op_vec_r[B_OUT] & io_out_ready);

  // Next-state, next-register and strobe logic; en=0 keeps everything as is.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    ir_s        = ir_r;
    op_vec_s    = op_vec_r;
    illegal_s   = illegal_r;
    halt_pend_s = halt_pend_r;
    mem_rd_s    = 1'b0;
    exec_stb_s  = 1'b0;
    if (en) begin
      case (state_r)
        st_fetch: begin
          mem_rd_s = 1'b1;
          pc_s     = pc_inc_s;
          state_s  = st_decode;
        end
        st_decode: begin
          ir_s      = mem_rdata;
          op_vec_s  = dec_op_s;
          illegal_s = (dec_op_s == 16'h0000);
          if (is_jump_s) begin
            // Operand byte is read now so it arrives in OPERAND.
            mem_rd_s = 1'b1;
            pc_s     = pc_inc_s;
            state_s  = st_operand;
          end else if (dec_op_s[B_IN] | dec_op_s[B_OUT]) begin
            state_s = st_iowait;
          end else if (dec_op_s[B_HLT]) begin
            halt_pend_s = 1'b1;
            state_s     = st_halt;
          end else begin
            state_s = st_exec;
          end
        end
        st_operand: begin
          if (taken_s) begin
            pc_s = target_s;
          end else begin
            pc_s = pc_r;
          end
          state_s = st_exec;
        end
        st_iowait: begin
          if (io_done_s) begin
            state_s = st_exec;
          end else begin
            state_s = st_iowait;
          end
        end
        st_exec: begin
          exec_stb_s = 1'b1;
          state_s    = st_fetch;
        end
        st_halt: begin
          // The halt op itself is announced once, on the first enabled cycle.
          exec_stb_s  = halt_pend_r;
          halt_pend_s = 1'b0;
          state_s     = st_halt;
        end
        default: begin
          state_s = st_fetch;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and architectural registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= st_fetch;
      pc_r        <= RESET_PC;
      ir_r        <= 8'h00;
      op_vec_r    <= 16'h0000;
      illegal_r   <= 1'b0;
      halt_pend_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ir_r        <= ir_s;
      op_vec_r    <= op_vec_s;
      illegal_r   <= illegal_s;
      halt_pend_r <= halt_pend_s;
    end
  end

  assign mem_rd   = mem_rd_s & ~rst;
  assign mem_addr = pc_r;
  assign exec_stb = exec_stb_s & ~rst;
  assign illegal  = exec_stb_s & illegal_r & ~rst;
  assign halted   = (state_r == st_halt);
  assign op_vec   = op_vec_r;
  assign ir       = ir_r;
  assign pc       = pc_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: scoreboard of expected executions
// plus per-feature timing checks, including a PC_W=4 instance for wraparound.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        mem_rd;
  logic [7:0]  mem_addr, mem_rdata;
  logic        z_flag, c_flag, io_in_valid, io_out_ready;
  logic [15:0] op_vec;
  logic [7:0]  ir;
  logic        exec_stb, illegal, halted;
  logic [7:0]  pc;

  logic        en4;
  logic        mem_rd4;
  logic [3:0]  mem_addr4, pc4;
  logic [7:0]  mem_rdata4, ir4;
  logic [15:0] op_vec4;
  logic        exec_stb4, illegal4, halted4;

  logic [7:0]  mem  [0:255];
  logic [7:0]  mem4 [0:15];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  ir;
    logic [15:0] op;
    logic        ill;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .z_flag(z_flag), .c_flag(c_flag),
    .io_in_valid(io_in_valid), .io_out_ready(io_out_ready), .op_vec(op_vec),
    .ir(ir), .exec_stb(exec_stb), .illegal(illegal), .halted(halted), .pc(pc)
  );

  instr_sequencer #(.PC_W(4), .RESET_PC(4'h0)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mem_rd(mem_rd4), .mem_addr(mem_addr4),
    .mem_rdata(mem_rdata4), .z_flag(1'b0), .c_flag(1'b0),
    .io_in_valid(1'b0), .io_out_ready(1'b0), .op_vec(op_vec4),
    .ir(ir4), .exec_stb(exec_stb4), .illegal(illegal4), .halted(halted4), .pc(pc4)
  );

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
  always @(posedge clk) if (mem_rd4) mem_rdata4 <= mem4[mem_addr4];

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 256; i++) mem[i] = 8'h70;
  endtask

  // Leaves the bench in cycle 0 (first FETCH) of the freshly reset DUT.
  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_exec(input int max, output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < max) begin
      if (exec_stb) got = 1'b1;
      else begin
        next_cyc();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    load_nops();
    mem[0] = 8'hCC;
    do_reset();
    repeat (3) next_cyc();
    rst = 1'b1;
    next_cyc();
    n_vec++;
    if (pc !== 8'h00 || ir !== 8'h00 || op_vec !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_regs: got pc=%h ir=%h op=%h, want 00 00 0000", pc, ir, op_vec);
    end
    n_vec++;
    if (mem_rd !== 1'b0 || exec_stb !== 1'b0 || illegal !== 1'b0 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got rd=%b stb=%b ill=%b hlt=%b, want all 0", mem_rd, exec_stb, illegal, halted);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_first_fetch: got rd=%b addr=%h, want 1 00", mem_rd, mem_addr);
    end
  endtask

  task automatic test_add();
    exp_t e;
    load_nops();
    mem[0] = 8'h90;
    sb_q.push_back('{ir: 8'h90, op: 16'h1000, ill: 1'b0});
    do_reset();
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL add_fetch0: got rd=%b addr=%h, want 1 00", mem_rd, mem_addr);
    end
    next_cyc();
    n_vec++;
    if (exec_stb !== 1'b0) begin
      n_err++;
      $display("FAIL add_c1_stb: got %b, want 0", exec_stb);
    end
    next_cyc();
    n_vec++;
    if (exec_stb !== 1'b1) begin
      n_err++;
      $display("FAIL add_c2_stb: got %b, want 1", exec_stb);
    end
    e = sb_q.pop_front();
    n_vec++;
    if (op_vec !== e.op || ir !== e.ir || illegal !== e.ill) begin
      n_err++;
      $display("FAIL add_exec: got op=%h ir=%h ill=%b, want %h %h %b", op_vec, ir, illegal, e.op, e.ir, e.ill);
    end
    next_cyc();
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h01 || exec_stb !== 1'b0 || op_vec !== 16'h1000) begin
      n_err++;
      $display("FAIL add_next_fetch: got rd=%b addr=%h stb=%b op=%h, want 1 01 0 1000", mem_rd, mem_addr, exec_stb, op_vec);
    end
  endtask

  task automatic test_decode();
    logic [7:0]  codes [15] = '{8'hFF, 8'h33, 8'hA1, 8'hCC, 8'hC3, 8'hC5, 8'h90, 8'h60,
                                8'hB0, 8'h50, 8'hA0, 8'hA3, 8'h70, 8'h71, 8'h81};
    logic [15:0] ops   [15] = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h2000, 16'h8000,
                                16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h0100, 16'h0080,
                                16'h0002, 16'h0000, 16'h0000};
    logic        ills  [15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t e;
    int   cyc;
    bit   got;
    load_nops();
    for (int i = 0; i < 15; i++) begin
      mem[i] = codes[i];
      sb_q.push_back('{ir: codes[i], op: ops[i], ill: ills[i]});
    end
    do_reset();
    for (int i = 0; i < 15; i++) begin
      wait_exec(8, cyc, got);
      n_vec++;
      if (!got || cyc != 2) begin
        n_err++;
        $display("FAIL decode_latency[%0d]: got stb=%b after %0d cycles, want 1 after 2", i, got, cyc);
      end
      e = sb_q.pop_front();
      n_vec++;
      if (op_vec !== e.op || ir !== e.ir || illegal !== e.ill) begin
        n_err++;
        $display("FAIL decode[%0d]: got op=%h ir=%h ill=%b, want %h %h %b", i, op_vec, ir, illegal, e.op, e.ir, e.ill);
      end
      next_cyc();
    end
  endtask

  task automatic test_jumps();
    logic [7:0]  ins  [6] = '{8'h31, 8'h31, 8'h32, 8'h32, 8'h30, 8'h31};
    logic [7:0]  tgt  [6] = '{8'h40, 8'h40, 8'h55, 8'h55, 8'h9A, 8'hFF};
    logic        zv   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        cv   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  npc  [6] = '{8'h40, 8'h02, 8'h55, 8'h02, 8'h9A, 8'hFF};
    logic [15:0] jop  [6] = '{16'h0020, 16'h0020, 16'h0010, 16'h0010, 16'h0040, 16'h0020};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      load_nops();
      mem[0] = ins[i];
      mem[1] = tgt[i];
      z_flag = ~zv[i];
      c_flag = ~cv[i];
      sb_q.push_back('{ir: ins[i], op: jop[i], ill: 1'b0});
      do_reset();
      next_cyc();
      n_vec++;
      if (mem_rd !== 1'b1 || mem_addr !== 8'h01) begin
        n_err++;
        $display("FAIL jump_operand_fetch[%0d]: got rd=%b addr=%h, want 1 01", i, mem_rd, mem_addr);
      end
      next_cyc();
      z_flag = zv[i];
      c_flag = cv[i];
      next_cyc();
      z_flag = ~zv[i];
      c_flag = ~cv[i];
      e = sb_q.pop_front();
      n_vec++;
      if (exec_stb !== 1'b1 || op_vec !== e.op || ir !== e.ir) begin
        n_err++;
        $display("FAIL jump_exec[%0d]: got stb=%b op=%h ir=%h, want 1 %h %h", i, exec_stb, op_vec, ir, e.op, e.ir);
      end
      next_cyc();
      n_vec++;
      if (mem_rd !== 1'b1 || mem_addr !== npc[i]) begin
        n_err++;
        $display("FAIL jump_target[%0d]: got rd=%b addr=%h, want 1 %h", i, mem_rd, mem_addr, npc[i]);
      end
    end
    z_flag = 1'b0;
    c_flag = 1'b0;
  endtask

  task automatic test_io();
    exp_t e;
    int   cyc;
    bit   got;
    load_nops();
    mem[0] = 8'h20;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    sb_q.push_back('{ir: 8'h20, op: 16'h0008, ill: 1'b0});
    do_reset();
    next_cyc();
    for (int k = 2; k <= 7; k++) begin
      next_cyc();
      n_vec++;
      if (exec_stb !== 1'b0 || pc !== 8'h01 || mem_rd !== 1'b0) begin
        n_err++;
        $display("FAIL in_wait[c%0d]: got stb=%b pc=%h rd=%b, want 0 01 0", k, exec_stb, pc, mem_rd);
      end
    end
    io_in_valid = 1'b1;
    next_cyc();
    e = sb_q.pop_front();
    n_vec++;
    if (exec_stb !== 1'b1 || op_vec !== e.op || ir !== e.ir) begin
      n_err++;
      $display("FAIL in_exec: got stb=%b op=%h ir=%h, want 1 %h %h", exec_stb, op_vec, ir, e.op, e.ir);
    end
    next_cyc();
    n_vec++;
    if (exec_stb !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 8'h01) begin
      n_err++;
      $display("FAIL in_after: got stb=%b rd=%b addr=%h, want 0 1 01", exec_stb, mem_rd, mem_addr);
    end
    // Output port ready before entry: one IOWAIT cycle only.
    load_nops();
    mem[0] = 8'h40;
    io_in_valid  = 1'b1;
    io_out_ready = 1'b1;
    sb_q.push_back('{ir: 8'h40, op: 16'h0004, ill: 1'b0});
    do_reset();
    wait_exec(10, cyc, got);
    n_vec++;
    if (!got || cyc != 3) begin
      n_err++;
      $display("FAIL out_latency: got stb=%b after %0d cycles, want 1 after 3", got, cyc);
    end
    e = sb_q.pop_front();
    n_vec++;
    if (op_vec !== e.op || ir !== e.ir) begin
      n_err++;
      $display("FAIL out_exec: got op=%h ir=%h, want %h %h", op_vec, ir, e.op, e.ir);
    end
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
  endtask

  task automatic test_halt();
    exp_t e;
    int   n_rd, n_stb, n_nothalt;
    load_nops();
    mem[0] = 8'h80;
    sb_q.push_back('{ir: 8'h80, op: 16'h0001, ill: 1'b0});
    do_reset();
    next_cyc();
    next_cyc();
    e = sb_q.pop_front();
    n_vec++;
    if (exec_stb !== 1'b1 || halted !== 1'b1 || op_vec !== e.op || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL halt_entry: got stb=%b hlt=%b op=%h ill=%b, want 1 1 %h 0", exec_stb, halted, op_vec, illegal, e.op);
    end
    n_rd = 0;
    n_stb = 0;
    n_nothalt = 0;
    for (int k = 0; k < 20; k++) begin
      next_cyc();
      if (mem_rd) n_rd++;
      if (exec_stb) n_stb++;
      if (!halted) n_nothalt++;
    end
    n_vec++;
    if (n_rd != 0 || n_stb != 0 || n_nothalt != 0) begin
      n_err++;
      $display("FAIL halt_parked: got rd=%0d stb=%0d unhalted=%0d, want 0 0 0", n_rd, n_stb, n_nothalt);
    end
    rst = 1'b1;
    next_cyc();
    next_cyc();
    n_vec++;
    if (halted !== 1'b0 || op_vec !== 16'h0000 || ir !== 8'h00 || pc !== 8'h00) begin
      n_err++;
      $display("FAIL halt_reset: got hlt=%b op=%h ir=%h pc=%h, want 0 0000 00 00", halted, op_vec, ir, pc);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL halt_restart: got rd=%b addr=%h, want 1 00", mem_rd, mem_addr);
    end
  endtask

  task automatic test_enable();
    logic [7:0]  pck [4] = '{8'h00, 8'h01, 8'h02, 8'h40};
    logic [15:0] opk [4] = '{16'h0000, 16'h0000, 16'h0020, 16'h0020};
    logic [7:0]  irk [4] = '{8'h00, 8'h00, 8'h31, 8'h31};
    exp_t e;
    int   cyc;
    bit   got;
    z_flag = 1'b1;
    for (int k = 0; k < 4; k++) begin
      load_nops();
      mem[0] = 8'h31;
      mem[1] = 8'h40;
      sb_q.push_back('{ir: 8'h31, op: 16'h0020, ill: 1'b0});
      do_reset();
      repeat (k) next_cyc();
      en = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
        if (j > 0) next_cyc();
        n_vec++;
        if (mem_rd !== 1'b0 || exec_stb !== 1'b0 || pc !== pck[k] || op_vec !== opk[k] || ir !== irk[k]) begin
          n_err++;
          $display("FAIL en_freeze[s%0d,%0d]: got rd=%b stb=%b pc=%h op=%h ir=%h, want 0 0 %h %h %h",
                   k, j, mem_rd, exec_stb, pc, op_vec, ir, pck[k], opk[k], irk[k]);
        end
      end
      next_cyc();
      en = 1'b1;
      #1;
      wait_exec(8, cyc, got);
      e = sb_q.pop_front();
      n_vec++;
      if (!got || cyc != 3 - k || op_vec !== e.op) begin
        n_err++;
        $display("FAIL en_resume[s%0d]: got stb=%b after %0d op=%h, want 1 after %0d op=%h", k, got, cyc, op_vec, 3 - k, e.op);
      end
      next_cyc();
      n_vec++;
      if (mem_rd !== 1'b1 || mem_addr !== 8'h40) begin
        n_err++;
        $display("FAIL en_target[s%0d]: got rd=%b addr=%h, want 1 40", k, mem_rd, mem_addr);
      end
    end
    z_flag = 1'b0;
    // Frozen in IOWAIT with the handshake already high.
    load_nops();
    mem[0] = 8'h20;
    io_in_valid = 1'b1;
    sb_q.push_back('{ir: 8'h20, op: 16'h0008, ill: 1'b0});
    do_reset();
    next_cyc();
    next_cyc();
    en = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) next_cyc();
      n_vec++;
      if (exec_stb !== 1'b0 || mem_rd !== 1'b0 || pc !== 8'h01) begin
        n_err++;
        $display("FAIL en_iowait[%0d]: got stb=%b rd=%b pc=%h, want 0 0 01", j, exec_stb, mem_rd, pc);
      end
    end
    next_cyc();
    en = 1'b1;
    #1;
    wait_exec(5, cyc, got);
    e = sb_q.pop_front();
    n_vec++;
    if (!got || cyc != 1 || op_vec !== e.op) begin
      n_err++;
      $display("FAIL en_iowait_resume: got stb=%b after %0d op=%h, want 1 after 1 op=%h", got, cyc, op_vec, e.op);
    end
    io_in_valid = 1'b0;
    // Frozen on the HALT entry cycle: the pulse is deferred, not lost.
    load_nops();
    mem[0] = 8'h80;
    do_reset();
    next_cyc();
    next_cyc();
    en = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) next_cyc();
      n_vec++;
      if (exec_stb !== 1'b0 || halted !== 1'b1) begin
        n_err++;
        $display("FAIL en_halt[%0d]: got stb=%b hlt=%b, want 0 1", j, exec_stb, halted);
      end
    end
    next_cyc();
    en = 1'b1;
    #1;
    n_vec++;
    if (exec_stb !== 1'b1 || op_vec !== 16'h0001) begin
      n_err++;
      $display("FAIL en_halt_pulse: got stb=%b op=%h, want 1 0001", exec_stb, op_vec);
    end
    next_cyc();
    n_vec++;
    if (exec_stb !== 1'b0) begin
      n_err++;
      $display("FAIL en_halt_single: got stb=%b, want 0", exec_stb);
    end
  endtask

  task automatic test_iowait_reset();
    exp_t e;
    int   cyc;
    bit   got;
    load_nops();
    mem[0] = 8'h20;
    io_in_valid = 1'b0;
    do_reset();
    repeat (3) next_cyc();
    do_reset();
    n_vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00 || exec_stb !== 1'b0 || op_vec !== 16'h0000) begin
      n_err++;
      $display("FAIL iowait_rst: got rd=%b addr=%h stb=%b op=%h, want 1 00 0 0000", mem_rd, mem_addr, exec_stb, op_vec);
    end
    io_in_valid = 1'b1;
    sb_q.push_back('{ir: 8'h20, op: 16'h0008, ill: 1'b0});
    wait_exec(8, cyc, got);
    e = sb_q.pop_front();
    n_vec++;
    if (!got || cyc != 3 || op_vec !== e.op) begin
      n_err++;
      $display("FAIL iowait_rerun: got stb=%b after %0d op=%h, want 1 after 3 op=%h", got, cyc, op_vec, e.op);
    end
    io_in_valid = 1'b0;
  endtask

  task automatic test_pc_wrap();
    logic [3:0] want;
    int         w;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      w = 0;
      while (!mem_rd4 && w < 6) begin
        next_cyc();
        w++;
      end
      want = 4'(i);
      n_vec++;
      if (mem_rd4 !== 1'b1 || mem_addr4 !== want) begin
        n_err++;
        $display("FAIL pc_wrap[%0d]: got rd=%b addr=%h, want 1 %h", i, mem_rd4, mem_addr4, want);
      end
      next_cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    en4 = 1'b1;
    z_flag = 1'b0;
    c_flag = 1'b0;
    io_in_valid = 1'b0;
    io_out_ready = 1'b0;
    load_nops();
    for (int i = 0; i < 16; i++) mem4[i] = 8'h70;
    test_reset();
    test_add();
    test_decode();
    test_jumps();
    test_io();
    test_halt();
    test_enable();
    test_iowait_reset();
    test_pc_wrap();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
